// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: single-port word memory answering an instruction-fetch
// channel and a load/store channel, one transaction at a time.
//   clk, rst                              clock, async active-high reset
//   PC, Inst_Req_Valid / Inst_Req_Ready   fetch request handshake
//   Instruction, Inst_Valid / Inst_Ready  fetch response handshake
//   Address, MemWrite, MemRead,
//   Write_data, Write_strb, Mem_Req_Ready data request handshake
//   Read_data, Read_data_Valid / _Ready   load response handshake
// Optional feature: define RESP_JITTER_EN to add 0..3 cycles of LFSR-driven
// extra latency to each accepted read or fetch.
module cpu_mem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  typedef enum logic [2:0] {IDLE, I_WAIT, I_RESP, D_WAIT, D_RESP, W_BUSY} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        word_q, word_d;      // word captured at acceptance
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ivalid_q, ivalid_d;
  logic               dvalid_q, dvalid_d;
  logic [CNT_W-1:0]   rd_load;             // counter preload for reads/fetches

  logic [31:0]        mem [DEPTH];

  logic [ADDR_W-1:0]  pc_idx, d_idx;
  logic               wr_accept;
  logic               unused_addr_bits;

  // Word index; byte offset and high bits are dropped so addresses wrap.
  assign pc_idx = PC[ADDR_W+1:2];
  assign d_idx  = Address[ADDR_W+1:2];
  assign unused_addr_bits = ^{PC[31:ADDR_W+2], PC[1:0], Address[31:ADDR_W+2], Address[1:0]};

  // Request readies; data channel wins over a simultaneous fetch.
  assign Mem_Req_Ready  = (state_q == IDLE) & ~rst;
  assign Inst_Req_Ready = Mem_Req_Ready & ~MemRead & ~MemWrite;

  assign wr_accept = (state_q == IDLE) & MemWrite & ~rst;

`ifdef RESP_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [4:0] jit_sum;

  // Extra latency from the pre-advance LFSR value, clamped to the counter range.
  assign jit_sum = 5'(LATENCY - 1) + {3'b000, lfsr_q[1:0]};
  assign rd_load = (jit_sum > 5'd15) ? 4'd15 : jit_sum[3:0];

  // x^8+x^6+x^5+x^4+1, advanced once per accepted read or fetch.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == IDLE && !MemWrite && (MemRead || Inst_Req_Valid))
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign rd_load = LAT_M1;
`endif

  // Next-state and response datapath.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    inst_d   = inst_q;
    rdata_d  = rdata_q;
    ivalid_d = ivalid_q;
    dvalid_d = dvalid_q;
    case (state_q)
      IDLE: begin
        if (MemWrite) begin
          state_d = W_BUSY;
          cnt_d   = LAT_M1;
        end else if (MemRead) begin
          state_d = D_WAIT;
          cnt_d   = rd_load;
          word_d  = mem[d_idx];
        end else if (Inst_Req_Valid) begin
          state_d = I_WAIT;
          cnt_d   = rd_load;
          word_d  = mem[pc_idx];
        end
      end
      I_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = I_RESP;
          ivalid_d = 1'b1;
          inst_d   = word_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      I_RESP: begin
        if (Inst_Ready) begin
          state_d  = IDLE;
          ivalid_d = 1'b0;
        end
      end
      D_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = D_RESP;
          dvalid_d = 1'b1;
          rdata_d  = word_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      D_RESP: begin
        if (Read_data_Ready) begin
          state_d  = IDLE;
          dvalid_d = 1'b0;
        end
      end
      W_BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      word_q   <= '0;
      inst_q   <= '0;
      rdata_q  <= '0;
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      inst_q   <= inst_d;
      rdata_q  <= rdata_d;
      ivalid_q <= ivalid_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Byte-enabled storage; never reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (Write_strb[i]) mem[d_idx][8*i +: 8] <= Write_data[8*i +: 8];
      end
    end
  end

  assign Instruction     = inst_q;
  assign Inst_Valid      = ivalid_q;
  assign Read_data       = rdata_q;
  assign Read_data_Valid = dvalid_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios plus random
// reads, fetches and strobed writes against an array memory model.
module tb_cpu_mem_responder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LAT    = 2;
  localparam int unsigned WORDS  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC, Address, Write_data, Instruction, Read_data;
  logic        Inst_Req_Valid, Inst_Req_Ready, Inst_Valid, Inst_Ready;
  logic        MemWrite, MemRead, Mem_Req_Ready, Read_data_Valid, Read_data_Ready;
  logic [3:0]  Write_strb;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem [WORDS];
  logic [31:0] last_rd;
  logic [31:0] last_inst;

  always #5 clk = ~clk;

  cpu_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
    .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  // Strobed store; memory is busy for exactly LAT cycles afterwards.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    check_eq("wr_req_ready", 32'(Mem_Req_Ready), 32'd1);
    Address = a; Write_data = d; Write_strb = s; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
    for (int k = 0; k < int'(LAT); k++) begin
      check_eq("wbusy_ready", 32'(Mem_Req_Ready), 32'd0);
      tick();
    end
    check_eq("wr_back_idle", 32'(Mem_Req_Ready), 32'd1);
  endtask

  // Read or fetch with `hold` cycles of response backpressure.
  task automatic do_read(input bit is_inst, input logic [31:0] a, input int hold,
                         output logic [31:0] got);
    logic [31:0] exp;
    int n;
    exp = ref_mem[widx(a)];
    if (is_inst) begin
      PC = a; Inst_Req_Valid = 1'b1;
      check_eq("if_req_ready", 32'(Inst_Req_Ready), 32'd1);
    end else begin
      Address = a; MemRead = 1'b1;
      check_eq("rd_req_ready", 32'(Mem_Req_Ready), 32'd1);
    end
    tick();
    Inst_Req_Valid = 1'b0; MemRead = 1'b0;
    n = 0;
    while (!(is_inst ? Inst_Valid : Read_data_Valid) && n < 40) begin
      tick();
      n++;
    end
    check_eq(is_inst ? "if_latency" : "rd_latency", 32'(n), 32'(LAT));
    got = is_inst ? Instruction : Read_data;
    check_eq(is_inst ? "if_data" : "rd_data", got, exp);
    if (is_inst) check_eq("rd_data_kept", Read_data, last_rd);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq("bp_valid", 32'(is_inst ? Inst_Valid : Read_data_Valid), 32'd1);
      check_eq("bp_data", is_inst ? Instruction : Read_data, exp);
    end
    if (is_inst) Inst_Ready = 1'b1; else Read_data_Ready = 1'b1;
    tick();
    Inst_Ready = 1'b0; Read_data_Ready = 1'b0;
    check_eq("valid_drop", 32'(is_inst ? Inst_Valid : Read_data_Valid), 32'd0);
    check_eq("data_after_drop", is_inst ? Instruction : Read_data, exp);
    check_eq("back_idle", 32'(Mem_Req_Ready), 32'd1);
    if (is_inst) last_inst = exp; else last_rd = exp;
  endtask

  initial begin
    logic [31:0] got, a, d;
    int n;
    rst = 1'b1;
    PC = '0; Address = '0; Write_data = '0; Write_strb = '0;
    Inst_Req_Valid = 1'b0; Inst_Ready = 1'b0;
    MemWrite = 1'b0; MemRead = 1'b0; Read_data_Ready = 1'b0;
    last_rd = '0; last_inst = '0;
    tick(); tick();
    check_eq("rst_inst_valid", 32'(Inst_Valid), 32'd0);
    check_eq("rst_rd_valid", 32'(Read_data_Valid), 32'd0);
    check_eq("rst_instruction", Instruction, 32'd0);
    check_eq("rst_read_data", Read_data, 32'd0);
    check_eq("rst_mem_ready", 32'(Mem_Req_Ready), 32'd0);
    check_eq("rst_inst_ready", 32'(Inst_Req_Ready), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(Mem_Req_Ready), 32'd1);

    // Give every word a known value so the model is fully defined.
    for (int w = 0; w < int'(WORDS); w++) do_write(32'(w) << 2, $urandom, 4'hF);

    // Fetch after store.
    do_write(32'h40, 32'h0000_0013, 4'hF);
    do_read(1'b1, 32'h40, 0, got);
    check_eq("fetch_const", got, 32'h0000_0013);

    // Partial strobes.
    do_write(32'h100, 32'hFFFF_FFFF, 4'hF);
    do_write(32'h100, 32'h1234_5678, 4'b0101);
    do_read(1'b0, 32'h100, 0, got);
    check_eq("strb_const", got, 32'hFF34_FF78);

    // Zero strobe is a no-op but still occupies the memory.
    do_write(32'h100, 32'h0BAD_0BAD, 4'h0);
    do_read(1'b0, 32'h100, 0, got);
    check_eq("strb0_const", got, 32'hFF34_FF78);

    // Backpressure for 5 cycles.
    do_read(1'b0, 32'h40, 5, got);

    // Address wrap and ignored byte offset.
    do_write(32'h1000, 32'hA5A5_A5A5, 4'hF);
    do_read(1'b0, 32'h0000, 0, got);
    check_eq("wrap_const", got, 32'hA5A5_A5A5);
    do_read(1'b1, 32'h0003, 1, got);
    check_eq("offset_const", got, 32'hA5A5_A5A5);

    // Simultaneous load and fetch: load first, fetch kept pending.
    PC = 32'h40; Inst_Req_Valid = 1'b1;
    Address = 32'h100; MemRead = 1'b1;
    #1;
    check_eq("coll_mem_ready", 32'(Mem_Req_Ready), 32'd1);
    check_eq("coll_inst_ready", 32'(Inst_Req_Ready), 32'd0);
    tick();
    MemRead = 1'b0; Read_data_Ready = 1'b1;
    n = 0;
    while (!Read_data_Valid && n < 40) begin tick(); n++; end
    check_eq("coll_rd_latency", 32'(n), 32'(LAT));
    check_eq("coll_rd_data", Read_data, 32'hFF34_FF78);
    check_eq("coll_no_inst", 32'(Inst_Valid), 32'd0);
    tick();
    Read_data_Ready = 1'b0;
    last_rd = 32'hFF34_FF78;
    check_eq("coll_inst_ready2", 32'(Inst_Req_Ready), 32'd1);
    tick();
    Inst_Req_Valid = 1'b0;
    n = 0;
    while (!Inst_Valid && n < 40) begin tick(); n++; end
    check_eq("coll_if_latency", 32'(n), 32'(LAT));
    check_eq("coll_if_data", Instruction, 32'h0000_0013);
    Inst_Ready = 1'b1;
    tick();
    Inst_Ready = 1'b0;
    check_eq("coll_if_drop", 32'(Inst_Valid), 32'd0);

    // Reset while a load is waiting: response discarded, memory kept.
    do_write(32'h200, 32'hCAFE_F00D, 4'hF);
    Address = 32'h200; MemRead = 1'b1;
    tick();
    MemRead = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_mem_ready", 32'(Mem_Req_Ready), 32'd0);
    check_eq("mid_rst_rd_data", Read_data, 32'd0);
    tick();
    rst = 1'b0;
    last_rd = '0;
    #1;
    check_eq("mid_rst_idle", 32'(Mem_Req_Ready), 32'd1);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (Read_data_Valid) n++;
      tick();
    end
    check_eq("mid_rst_no_valid", 32'(n), 32'd0);
    do_read(1'b0, 32'h200, 0, got);
    check_eq("mid_rst_mem_kept", got, 32'hCAFE_F00D);

    // Random mix of operations.
    for (int t = 0; t < 120; t++) begin
      a = $urandom;
      d = $urandom;
      case ($urandom_range(0, 2))
        0: do_write(a, d, 4'($urandom_range(0, 15)));
        1: do_read(1'b0, a, int'($urandom_range(0, 3)), got);
        default: do_read(1'b1, a, int'($urandom_range(0, 3)), got);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: word-address width, giving 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, legal range 1..15: cycles from request acceptance to response.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port PC, input, 32: instruction fetch byte address.
REQ-006 SHALL have port Inst_Req_Valid, input, 1: fetch request valid.
REQ-007 SHALL have port Inst_Req_Ready, output, 1: fetch request accepted.
REQ-008 SHALL have port Instruction, output, 32: fetched word.
REQ-009 SHALL have port Inst_Valid, output, 1: Instruction valid.
REQ-010 SHALL have port Inst_Ready, input, 1: initiator takes Instruction.
REQ-011 SHALL have port Address, input, 32: data byte address.
REQ-012 SHALL have ports MemWrite and MemRead, input, 1 each: data write and data read request.
REQ-013 SHALL have ports Write_data, input, 32, and Write_strb, input, 4: store data and byte enables; bit i enables byte i.
REQ-014 SHALL have port Mem_Req_Ready, output, 1: data request accepted.
REQ-015 SHALL have port Read_data, output, 32: load data.
REQ-016 SHALL have port Read_data_Valid, output, 1: Read_data valid.
REQ-017 SHALL have port Read_data_Ready, input, 1: initiator takes Read_data.

Function
REQ-018 SHALL implement FSM states IDLE, I_WAIT, I_RESP, D_WAIT, D_RESP and W_BUSY.
REQ-019 SHALL form word index = addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 are ignored, so addresses wrap.
REQ-020 SHALL drive Mem_Req_Ready = (state==IDLE) and Inst_Req_Ready = (state==IDLE) & ~MemRead & ~MemWrite, combinationally.
REQ-021 SHALL give data requests priority when both channels request in IDLE; the fetch request stays pending.
REQ-022 SHALL, in IDLE with MemWrite=1, write each byte with Write_strb bit set at that edge; then W_BUSY for LATENCY cycles; then IDLE; no response is produced.
REQ-023 SHALL treat MemWrite=MemRead=1 as a write only.
REQ-024 SHALL, on accepting a read or fetch, capture the memory word at the acceptance edge.
REQ-025 SHALL move to I_WAIT or D_WAIT with a 4-bit counter loaded with LATENCY-1, and enter I_RESP or D_RESP when the counter reaches 0; with LATENCY=1 it enters the RESP state directly.
REQ-026 SHALL raise Inst_Valid/Read_data_Valid exactly LATENCY cycles after the acceptance edge.
REQ-027 SHALL, in a RESP state, hold Valid and data stable until Ready is sampled high, then return to IDLE on that edge.
REQ-028 SHALL hold the captured data: a write accepted later cannot change a pending response.
REQ-029 SHALL keep Instruction and Read_data unchanged after Valid drops, until the next response.
REQ-030 SHALL treat Write_strb=0 as an accepted no-op write, including W_BUSY.

Reset
REQ-031 SHALL, while rst=1, force IDLE, counter 0, Inst_Valid=Read_data_Valid=0, Instruction=Read_data=0, and both Ready outputs 0.
REQ-032 SHALL, on reset mid-transaction, discard pending responses and keep already-committed writes.
REQ-033 SHALL leave memory contents unaffected by reset.

Configuration
REQ-034 SHALL, with macro RESP_JITTER_EN defined, add an 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset 8'hA5) that advances once per accepted read or fetch.
REQ-035 SHALL, with RESP_JITTER_EN defined, add lfsr[1:0] (pre-advance value) to that request's latency; writes are unaffected.
REQ-036 SHALL, without RESP_JITTER_EN, have fixed LATENCY and no LFSR logic.

Verification
REQ-037 Fetch: write 32'h00000013 at 0x40; PC=0x40 -> Inst_Valid rises 2 cycles after acceptance with Instruction=32'h00000013.
REQ-038 Strobe write: word 0x100=32'hFFFFFFFF; write 32'h12345678, strb 4'b0101 -> readback 32'hFF34FF78.
REQ-039 Backpressure: hold Read_data_Ready=0 for 5 cycles -> Valid and data stay stable; single return to IDLE after Ready=1.
REQ-040 Collision: Inst_Req_Valid and MemRead together in IDLE -> Mem_Req_Ready=1, Inst_Req_Ready=0; fetch served after load completes.
REQ-041 Wrap: ADDR_W=10, write 0xA5A5A5A5 at 0x1000 -> read at 0x0000 returns 0xA5A5A5A5.
REQ-042 Reset in D_WAIT -> Read_data_Valid never asserts; IDLE next cycle after rst release.
